serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Sequencer that performs a wide unsigned add (WIDTH = CHUNK_BITS*NUM_CHUNKS) by time-multiplexing
//  one CHUNK_BITS-wide ripple adder (adder_nbit) over successive chunks, LSB chunk first.
//  The carry is registered between chunks. A start/busy/done handshake frames each operation.
//  It sits between a requesting controller and the shared narrow adder datapath.
// PARAMETERS
//  CHUNK_BITS   4   width of the adder_nbit instance (bits per chunk)
//  NUM_CHUNKS   4   chunks per operation; WIDTH = CHUNK_BITS*NUM_CHUNKS (16 by default)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  start      in   1      request; sampled only in IDLE
//  op_a       in   WIDTH  operand A; latched on accepted start
//  op_b       in   WIDTH  operand B; latched on accepted start
//  carry_in   in   1      carry into chunk 0; latched on accepted start
//  busy       out  1      high while in ADD state
//  done       out  1      one-cycle pulse; sum/overflow are valid from this cycle onward
//  sum        out  WIDTH  result (op_a+op_b+carry_in) mod 2^WIDTH
//  overflow   out  1      carry out of the final chunk (unsigned overflow)
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
//  - Reset: state=IDLE, chunk_idx=0, carry_reg=0, operand regs=0, busy=0, done=0, sum=0, overflow=0.
//  - FSM with states IDLE, ADD and DONE:
//    IDLE -> ADD when start=1. Latch op_a, op_b and carry_in (carry_reg<=carry_in). Set chunk_idx=0.
//    ADD: on each edge, store adder_nbit sum of chunk[chunk_idx] into result chunk chunk_idx.
//      On the same edge, carry_reg<=adder carry-out and chunk_idx++.
//      ADD -> DONE on the edge that stores chunk NUM_CHUNKS-1.
//      On that edge, sum<=the full result and overflow<=final carry-out.
//    DONE -> IDLE unconditionally after one cycle. done=1 only in DONE.
//  - Latency: start is sampled at edge E0. done is high in the cycle after edge E(NUM_CHUNKS).
//    Throughput is one operation per NUM_CHUNKS+2 cycles.
//  - sum/overflow are updated only on the ADD->DONE edge. They hold their value through later IDLE and ADD
//    cycles until the next completion.
//  - start in the ADD or DONE state is ignored (not queued). Operand changes after acceptance have no effect.
//  - Chunk indexing: chunk k = bits [k*CHUNK_BITS +: CHUNK_BITS]. chunk_idx width is $clog2(NUM_CHUNKS), minimum 1.
//  - NUM_CHUNKS=1 is legal: ADD lasts one cycle.
//  - Reset mid-operation aborts: no done pulse, outputs return to reset values. Reset wins over start.
//  - busy and done are never high simultaneously.
//  - Widths: all adds are unsigned. No sign extension. The carry is 1 bit.
// STRUCTURE
//  - Package adder_ctrl_pkg contains: typedef enum logic [1:0] {IDLE, ADD, DONE} add_state_t;
//    and localparam DEFAULT_CHUNK_BITS=4.
//  - One sub-module: adder_nbit (parameter BIT_WIDTH=CHUNK_BITS).
//    Ports are a, b, carry_in, sum, overflow. It is purely combinational and instanced once.
//  - Remaining logic in this block: registered operands, chunk counter, carry register, result register and
//    next-state logic.
// TESTING (defaults: WIDTH=16)
//  1. rst=1 for 2 cycles -> busy=0, done=0, sum=0x0000, overflow=0.
//  2. start with A=0x1234, B=0x0001, cin=0 -> busy for 4 cycles. done pulses once.
//     sum=0x1235, overflow=0.
//  3. A=0xFFFF, B=0x0001, cin=0 -> carry ripples through all chunks. sum=0x0000, overflow=1.
//  4. A=0xFFFF, B=0xFFFF, cin=1 -> sum=0xFFFF, overflow=1. Then start is held high continuously.
//     New ops are accepted only from IDLE, one per 6 cycles.
//  5. During ADD, change op_a/op_b and pulse start -> ignored; result matches the latched operands.
//     sum holds its previous value until done.
//  6. Assert rst in the 2nd ADD cycle of A=0x0F0F+B=0x00F1 -> no done, outputs zero.
//     A fresh op after reset computes correctly.
//  - Also run a random sweep of 10k ops checked against (A+B+cin) mod 2^16 and bit 16 as overflow.

Source files
------------

// File: rtl/adder_ctrl_pkg.sv
// Shared types and defaults for the chunked serial adder controller.
package adder_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ADD, DONE} add_state_t;

    localparam int unsigned DEFAULT_CHUNK_BITS = 4;

endpackage

// File: rtl/adder_nbit.sv
// Combinational BIT_WIDTH-bit ripple adder with carry in and carry out.
module adder_nbit #(
    parameter int unsigned BIT_WIDTH = 4
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);

    logic [BIT_WIDTH:0] full;

    assign full     = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};
    assign sum      = full[BIT_WIDTH-1:0];
    assign overflow = full[BIT_WIDTH];

endmodule

// File: rtl/serial_add_ctrl.sv
// Wide unsigned add built by stepping one narrow adder over the operands, LSB chunk first.
module serial_add_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter  int unsigned CHUNK_BITS = DEFAULT_CHUNK_BITS,
    parameter  int unsigned NUM_CHUNKS = 4,
    localparam int unsigned WIDTH      = CHUNK_BITS * NUM_CHUNKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    localparam int unsigned IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    add_state_t       state;
    logic [IDX_W-1:0] chunk_idx;
    logic             carry_reg;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] res_q;

    logic [CHUNK_BITS-1:0] a_chunk;
    logic [CHUNK_BITS-1:0] b_chunk;
    logic [CHUNK_BITS-1:0] chunk_sum;
    logic                  chunk_cout;
    logic [WIDTH-1:0]      res_next;

    // Select the current chunk and merge the adder result into the partial sum.
    always_comb begin
        a_chunk  = op_a_q[int'(chunk_idx) * CHUNK_BITS +: CHUNK_BITS];
        b_chunk  = op_b_q[int'(chunk_idx) * CHUNK_BITS +: CHUNK_BITS];
        res_next = res_q;
        res_next[int'(chunk_idx) * CHUNK_BITS +: CHUNK_BITS] = chunk_sum;
    end

    adder_nbit #(
        .BIT_WIDTH (CHUNK_BITS)
    ) u_adder (
        .a        (a_chunk),
        .b        (b_chunk),
        .carry_in (carry_reg),
        .sum      (chunk_sum),
        .overflow (chunk_cout)
    );

    // Sequencer: operands latch on accept; sum/overflow only change on the final chunk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            chunk_idx <= '0;
            carry_reg <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            res_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a_q    <= op_a;
                        op_b_q    <= op_b;
                        carry_reg <= carry_in;
                        chunk_idx <= '0;
                        busy      <= 1'b1;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    res_q     <= res_next;
                    carry_reg <= chunk_cout;
                    if (chunk_idx == LAST_IDX) begin
                        chunk_idx <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        sum       <= res_next;
                        overflow  <= chunk_cout;
                        state     <= DONE;
                    end else begin
                        chunk_idx <= IDX_W'(chunk_idx + 1'b1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed vectors, corner sequences and a random sweep.
module tb_serial_add_ctrl;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         overflow;

    int n_cmp = 0;
    int n_bad = 0;

    serial_add_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Entered at a negedge with the DUT idle; leaves at a negedge with the DUT idle again.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] exp_sum, input logic exp_ovf);
        int busy_cnt;
        int cyc;
        bit both;
        busy_cnt = 0;
        cyc      = 0;
        both     = 1'b0;
        start    = 1'b1;
        op_a     = a;
        op_b     = b;
        carry_in = cin;
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
            if (busy && done) both = 1'b1;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("latency", 32'(cyc), 32'd4);
        chk("busy_cycles", 32'(busy_cnt), 32'd4);
        chk("busy_and_done", 32'(both), 32'd0);
        chk("sum", 32'(sum), 32'(exp_sum));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        @(negedge clk);
        chk("done_one_pulse", 32'(done), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int done_idx[$];
        bit saw_done;
        logic [W:0] ref_full;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;

        vecs[0] = '{16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0};

        rst      = 1'b1;
        start    = 1'b0;
        op_a     = '0;
        op_b     = '0;
        carry_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_ovf);

        // start held high: accepted only from IDLE, one op every 6 cycles
        start    = 1'b1;
        op_a     = 16'hFFFF;
        op_b     = 16'hFFFF;
        carry_in = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (busy && done) chk("held_busy_and_done", 32'd1, 32'd0);
            if (done) done_idx.push_back(i);
        end
        start = 1'b0;
        chk("held_done_count", 32'(done_idx.size()), 32'd3);
        if (done_idx.size() == 3) begin
            chk("held_spacing_1", 32'(done_idx[1] - done_idx[0]), 32'd6);
            chk("held_spacing_2", 32'(done_idx[2] - done_idx[1]), 32'd6);
        end
        chk("held_sum", 32'(sum), 32'hFFFF);
        chk("held_ovf", 32'(overflow), 32'd1);

        // operand changes and start pulses during ADD are ignored
        do_op(16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0);
        start    = 1'b1;
        op_a     = 16'h1111;
        op_b     = 16'h2222;
        carry_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op_a     = 16'hFFFF;
        op_b     = 16'hFFFF;
        carry_in = 1'b1;
        start    = 1'b1;
        chk("ign_sum_hold1", 32'(sum), 32'h0406);
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("ign_sum_hold2", 32'(sum), 32'h0406);
        @(negedge clk);
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_sum", 32'(sum), 32'h3333);
        chk("ign_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        chk("ign_done_low", 32'(done), 32'd0);
        @(negedge clk);
        chk("ign_not_queued", 32'(busy), 32'd0);

        // reset in the 2nd ADD cycle aborts the op
        start    = 1'b1;
        op_a     = 16'h0F0F;
        op_b     = 16'h00F1;
        carry_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_ovf", 32'(overflow), 32'd0);
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort_quiet", 32'(saw_done), 32'd0);
        do_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);

        // random sweep against plain wide arithmetic
        for (int i = 0; i < 10000; i++) begin
            ra       = W'($urandom);
            rb       = W'($urandom);
            rc       = 1'($urandom);
            ref_full = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
            do_op(ra, rb, rc, ref_full[W-1:0], ref_full[W]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
